// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: program counter, next-PC selection from the EX branch
// control, instruction-memory read and the IF/ID pipeline register.
//
// state | meaning
// BOOT  | first cycle out of reset, no fetch issued
// RUN   | fetching; sequential, stalled or redirected
// HALT  | misaligned redirect target trapped, only reset leaves
module fetch_pc_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_ex_valid,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_alu_target,
  input  logic [31:0] i_pc_imm,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_imem_raddr,
  output logic        o_imem_ren,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_if_inst,
  output logic        o_if_valid,
  output logic        o_flush,
  output logic        o_trap,
  output logic [31:0] o_trap_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        misaligned;

  assign pc_plus4   = pc + 32'd4;
  assign redirect   = (state == RUN) && i_ex_valid && (i_pc_sel != 2'b11);
  // jalr-style targets drop bit 0; bit 1 set still means a misaligned fetch
  assign target     = i_pc_sel[0] ? i_pc_imm : (i_alu_target & ~32'h1);
  assign misaligned = (target[1:0] != 2'b00);

  assign o_imem_raddr = pc;
  assign o_imem_ren   = (state == RUN);
  assign o_flush      = redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= BOOT;
      pc         <= RESET_ADDR;
      o_if_pc    <= 32'h0;
      o_if_pc4   <= 32'h0;
      o_if_inst  <= 32'h0;
      o_if_valid <= 1'b0;
      o_trap     <= 1'b0;
      o_trap_pc  <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect) begin
            o_if_valid <= 1'b0;
            if (misaligned) begin
              o_trap    <= 1'b1;
              o_trap_pc <= target;
              state     <= HALT;
            end else begin
              pc <= target;
            end
          end else if (!i_stall) begin
            o_if_pc    <= pc;
            o_if_pc4   <= pc_plus4;
            o_if_inst  <= i_imem_rdata;
            o_if_valid <= 1'b1;
            pc         <= pc_plus4;
          end
        end
        HALT: o_if_valid <= 1'b0;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: a behavioural model predicts every cycle's
// outputs into a queue, a monitor pops and compares them against two DUT instances.
module tb_fetch_pc_stage;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_ex_valid = 1'b0;
  logic [1:0]  i_pc_sel = 2'b11;
  logic [31:0] i_alu_target = 32'h0;
  logic [31:0] i_pc_imm = 32'h0;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_imem_raddr, o_if_pc, o_if_pc4, o_if_inst, o_trap_pc;
  logic        o_imem_ren, o_if_valid, o_flush, o_trap;

  logic [31:0] b_rdata, b_raddr, b_if_pc, b_if_pc4, b_if_inst, b_trap_pc;
  logic        b_ren, b_if_valid, b_flush, b_trap;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign i_imem_rdata = memf(o_imem_raddr);
  assign b_rdata      = memf(b_raddr);

  fetch_pc_stage #(.RESET_ADDR(RST_A)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_ex_valid(i_ex_valid),
    .i_pc_sel(i_pc_sel), .i_alu_target(i_alu_target), .i_pc_imm(i_pc_imm),
    .i_imem_rdata(i_imem_rdata), .o_imem_raddr(o_imem_raddr), .o_imem_ren(o_imem_ren),
    .o_if_pc(o_if_pc), .o_if_pc4(o_if_pc4), .o_if_inst(o_if_inst),
    .o_if_valid(o_if_valid), .o_flush(o_flush), .o_trap(o_trap), .o_trap_pc(o_trap_pc)
  );

  // second instance only runs sequentially, to exercise the 32-bit PC wrap
  fetch_pc_stage #(.RESET_ADDR(RST_B)) dut_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(1'b0), .i_ex_valid(1'b0),
    .i_pc_sel(2'b11), .i_alu_target(32'h0), .i_pc_imm(32'h0),
    .i_imem_rdata(b_rdata), .o_imem_raddr(b_raddr), .o_imem_ren(b_ren),
    .o_if_pc(b_if_pc), .o_if_pc4(b_if_pc4), .o_if_inst(b_if_inst),
    .o_if_valid(b_if_valid), .o_flush(b_flush), .o_trap(b_trap), .o_trap_pc(b_trap_pc)
  );

  typedef struct {
    logic [31:0] raddr;
    logic        ren;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] b_raddr;
    logic        b_trap;
  } exp_t;

  exp_t q[$];

  // model: 0 = waiting out the boot cycle, 1 = fetching, 2 = trapped
  int          m_phase = 0;
  logic [31:0] m_pc = RST_A;
  logic [31:0] m_if_pc = 0, m_if_pc4 = 0, m_if_inst = 0, m_trap_pc = 0;
  logic        m_if_valid = 0, m_trap = 0;
  logic [31:0] m_b_pc = RST_B;
  bit          m_b_boot = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic stall, input logic exv,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] imm);
    exp_t        e;
    logic        redir;
    logic [31:0] tgt;
    @(negedge i_clk);
    i_rst_n = rst_n; i_stall = stall; i_ex_valid = exv;
    i_pc_sel = sel; i_alu_target = alu; i_pc_imm = imm;
    if (!rst_n) begin
      m_phase = 0; m_pc = RST_A; m_if_pc = 0; m_if_pc4 = 0; m_if_inst = 0;
      m_if_valid = 0; m_trap = 0; m_trap_pc = 0; m_b_pc = RST_B; m_b_boot = 1;
    end
    redir = rst_n && (m_phase == 1) && exv && (sel != 2'b11);
    tgt   = sel[0] ? imm : {alu[31:1], 1'b0};
    e.raddr = m_pc; e.ren = rst_n && (m_phase == 1); e.flush = redir;
    e.if_pc = m_if_pc; e.if_pc4 = m_if_pc4; e.if_inst = m_if_inst;
    e.if_valid = m_if_valid; e.trap = m_trap; e.trap_pc = m_trap_pc;
    e.b_raddr = m_b_pc; e.b_trap = 1'b0;
    q.push_back(e);
    if (rst_n) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (redir) begin
          m_if_valid = 0;
          if (tgt % 4 != 0) begin
            m_trap = 1; m_trap_pc = tgt; m_phase = 2;
          end else m_pc = tgt;
        end else if (!stall) begin
          m_if_pc = m_pc; m_if_pc4 = m_pc + 32'd4; m_if_inst = memf(m_pc);
          m_if_valid = 1; m_pc = m_pc + 32'd4;
        end
      end else m_if_valid = 0;
      if (m_b_boot) m_b_boot = 0;
      else m_b_pc = m_b_pc + 32'd4;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("raddr",    o_imem_raddr, e.raddr);
        chk("ren",      {31'h0, o_imem_ren}, {31'h0, e.ren});
        chk("flush",    {31'h0, o_flush}, {31'h0, e.flush});
        chk("if_valid", {31'h0, o_if_valid}, {31'h0, e.if_valid});
        if (e.if_valid) begin
          chk("if_pc",   o_if_pc, e.if_pc);
          chk("if_pc4",  o_if_pc4, e.if_pc4);
          chk("if_inst", o_if_inst, e.if_inst);
        end
        chk("trap",     {31'h0, o_trap}, {31'h0, e.trap});
        chk("trap_pc",  o_trap_pc, e.trap_pc);
        chk("wrap_raddr", b_raddr, e.b_raddr);
        chk("wrap_trap",  {31'h0, b_trap}, {31'h0, e.b_trap});
      end
    end
  end

  initial begin : driver
    int halt_cnt;
    logic [31:0] alu, imm;
    // reset, boot and four sequential fetches, then redirect at pc 0x10
    step(0, 0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 1, 2'b10, 32'h100, 0);
    step(1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 2'b11, 0, 0);
    step(1, 1, 1, 2'b01, 0, 32'h40);
    step(1, 0, 0, 2'b01, 0, 32'h80);
    step(1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 1, 2'b00, 32'h201, 0);
    step(1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 1, 2'b01, 0, 32'h102);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 2'b10, 32'h300, 0);
    step(0, 0, 0, 2'b11, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0);

    halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      alu = ($urandom & 32'h0000_0FFC) | ($urandom % 2);
      if ($urandom % 20 == 0) alu = alu | 32'h2;
      imm = $urandom & 32'h0000_0FFC;
      if ($urandom % 16 == 0) imm = imm | $urandom_range(1, 3);
      halt_cnt = (m_phase == 2) ? halt_cnt + 1 : 0;
      if (halt_cnt > 3 || $urandom % 200 == 0) begin
        step(0, 0, 0, 2'b11, 0, 0);
        halt_cnt = 0;
      end else begin
        step(1, ($urandom % 4) == 0, ($urandom % 3) == 0, 2'($urandom), alu, imm);
      end
    end

    @(negedge i_clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
